// File: rtl/horner_coeff_sequencer.sv
// horner_coeff_sequencer
// Read-side consumer of the coefficient FIFO. After the loader writes the NaN
// start marker, each evaluation request streams n stored coefficients to the
// Horner MAC over valid/ready. After the last coefficient it pulses fifo_redo_o,
// so the next sample replays the same coefficient set.
//
// Ports:
//   clk_i, rstn_i          clock, async active-low reset
//   marker_i               start-marker strobe (arms from IDLE only)
//   clear_i                synchronous disarm/abort, highest priority
//   eval_req_i, n_coeff_i  evaluation request and coefficient count
//   fifo_empty_i           FIFO empty flag (sampled at request acceptance)
//   fifo_data_i            FIFO read data, valid the cycle after a read
//   fifo_rd_en_o           FIFO read/advance
//   fifo_redo_o            FIFO read-pointer rewind pulse
//   coeff_o/_valid_o/_last_o, coeff_ready_i   MAC stream
//   armed_o, busy_o, done_o, err_o, eval_cnt_o   status
//
// state    | meaning
// S_IDLE   | waiting for the start marker
// S_ARMED  | marker seen, waiting for an evaluation request
// S_STREAM | presenting coefficient idx to the MAC
// S_REWIND | one-cycle completion, done pulse, then back to ARMED
module horner_coeff_sequencer #(
  parameter  int DATA_W     = 32,
  parameter  int MAX_COEFF  = 16,
  parameter  int EVAL_CNT_W = 16,
  localparam int CNT_W      = $clog2(MAX_COEFF + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  marker_i,
  input  logic                  clear_i,
  input  logic                  eval_req_i,
  input  logic [CNT_W-1:0]      n_coeff_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_W-1:0]     fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  fifo_redo_o,
  output logic [DATA_W-1:0]     coeff_o,
  output logic                  coeff_valid_o,
  output logic                  coeff_last_o,
  input  logic                  coeff_ready_i,
  output logic                  armed_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [EVAL_CNT_W-1:0] eval_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_STREAM, S_REWIND} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_n;
  logic                  r_err;
  logic [EVAL_CNT_W-1:0] r_eval_cnt;

  logic w_n_ok;
  logic w_accept;
  logic w_last;
  logic w_hs;

  assign w_n_ok   = (n_coeff_i != '0) && (n_coeff_i <= CNT_W'(MAX_COEFF));
  assign w_accept = (r_state == S_ARMED) && eval_req_i && w_n_ok && !fifo_empty_i;
  assign w_last   = (r_idx == r_n - 1'b1);
  assign w_hs     = (r_state == S_STREAM) && coeff_ready_i;

  // The first read is issued in the accept cycle so data is present when
  // coeff_valid_o rises; later reads prefetch on every non-final handshake.
  assign fifo_rd_en_o  = !clear_i && (w_accept || (w_hs && !w_last));
  assign fifo_redo_o   = !clear_i && w_hs && w_last;

  assign coeff_valid_o = (r_state == S_STREAM);
  assign coeff_o       = (r_state == S_STREAM) ? fifo_data_i : '0;
  assign coeff_last_o  = (r_state == S_STREAM) && w_last;
  assign armed_o       = (r_state != S_IDLE);
  assign busy_o        = (r_state == S_STREAM) || (r_state == S_REWIND);
  assign done_o        = (r_state == S_REWIND) && !clear_i;
  assign err_o         = r_err;
  assign eval_cnt_o    = r_eval_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_n        <= '0;
      r_err      <= 1'b0;
      r_eval_cnt <= '0;
    end else if (clear_i) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (marker_i) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (eval_req_i) begin
            if (!w_n_ok) begin
              r_err <= 1'b1;
            end else if (fifo_empty_i) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_n     <= n_coeff_i;
              r_idx   <= '0;
              r_state <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (w_last) r_state <= S_REWIND;
            else        r_idx   <= r_idx + 1'b1;
          end
        end
        S_REWIND: begin
          r_eval_cnt <= r_eval_cnt + 1'b1;
          r_state    <= S_ARMED;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/horner_coeff_sequencer.md
Name: horner_coeff_sequencer

Overview:
Consumer stage on the read side of the coefficient FIFO in the nonlinear-approximation datapath. Once the loader writes the NaN start marker (0x7F900000), the block is armed. Each evaluation request then streams the stored polynomial coefficients, in FIFO order, to the Horner MAC over a valid/ready handshake. After the last coefficient it pulses the FIFO redo line, which rewinds the read pointer so the next sample replays the same coefficient set.

Parameters:
DATA_W, 32, coefficient width (IEEE-754 single).
MAX_COEFF, 16, maximum coefficients per evaluation; CNT_W = $clog2(MAX_COEFF+1).
EVAL_CNT_W, 16, width of the completed-evaluation counter.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rstn_i  in  1  asynchronous active-low reset.
marker_i  in  1  start-marker strobe from FIFO write side; arms the block.
clear_i  in  1  synchronous disarm/abort.
eval_req_i  in  1  request one coefficient sequence; accepted only in ARMED.
n_coeff_i  in  CNT_W  coefficients per evaluation; sampled on accepted request.
fifo_empty_i  in  1  FIFO empty flag.
fifo_data_i  in  DATA_W  FIFO read data; valid the cycle after fifo_rd_en_o, held until the next pulse.
fifo_rd_en_o  out  1  FIFO read enable/advance.
fifo_redo_o  out  1  one-cycle pulse; rewinds the FIFO read pointer.
coeff_o  out  DATA_W  coefficient to MAC.
coeff_valid_o  out  1  coeff_o valid.
coeff_last_o  out  1  marks the final coefficient of the sequence.
coeff_ready_i  in  1  MAC accepts the coefficient.
armed_o  out  1  marker seen and not cleared.
busy_o  out  1  state is STREAM or REWIND.
done_o  out  1  one-cycle pulse at evaluation completion.
err_o  out  1  sticky underflow/config error; cleared by reset or clear_i.
eval_cnt_o  out  EVAL_CNT_W  completed evaluations; wraps modulo 2^EVAL_CNT_W.

Behaviour:
- Reset (async, rstn_i=0): state IDLE. All outputs 0; coeff_o=0; internal counters 0.
- States: IDLE, ARMED, STREAM, REWIND.
- IDLE:
  - marker_i=1 -> ARMED.
  - eval_req_i is ignored.
- ARMED (armed_o=1):
  - eval_req_i=1 with 1<=n_coeff_i<=MAX_COEFF and fifo_empty_i=0: assert fifo_rd_en_o combinationally in the same cycle, latch n, set idx=0 -> STREAM.
  - eval_req_i=1 with fifo_empty_i=1: err_o=1 -> IDLE (disarm).
  - eval_req_i=1 with n_coeff_i=0 or n_coeff_i>MAX_COEFF: err_o=1, stay ARMED, no FIFO read.
- STREAM:
  - coeff_valid_o=1 and coeff_o=fifo_data_i; coeff_last_o=(idx==n-1).
  - Handshake on coeff_valid_o & coeff_ready_i.
    - Not last: fifo_rd_en_o=1 in the same cycle, idx++. Throughput is 1 coefficient/cycle while ready stays high.
    - Last: fifo_redo_o=1 in the same cycle, no read -> REWIND.
  - coeff_ready_i=0: no read; coeff_o is held stable (FIFO holds its data).
- REWIND (1 cycle): done_o=1, eval_cnt_o++, coeff_valid_o=0 -> ARMED.
- Latency: eval_req_i accepted at cycle T -> first coeff_valid_o at T+1. With ready held high, the last coefficient appears at T+n, done_o at T+n+1, and the next request is accepted at T+n+2.
- fifo_empty_i is sampled only at request acceptance.
- marker_i outside IDLE is ignored (no re-arm effect).
- clear_i has priority over all other events, in every state:
  - next state IDLE; err_o cleared; idx cleared; eval_cnt_o kept.
  - No redo or done is issued.
  - fifo_rd_en_o is suppressed in that cycle.
- clear_i and marker_i in the same cycle: the result is IDLE.
- A mid-stream async reset abandons the sequence and drives all outputs to 0 immediately.
- fifo_rd_en_o and fifo_redo_o are never high in the same cycle.
- coeff_valid_o, once high, stays high until the handshake, clear_i or reset.

Test Plan:
1. Reset, marker_i pulse, eval_req_i with n_coeff_i=4, ready=1, FIFO holding C0..C3 -> fifo_rd_en_o high for 4 cycles (T..T+3); coeff_o = C0,C1,C2,C3 at T+1..T+4 with coeff_last_o at T+4; fifo_redo_o at T+4; done_o at T+5; eval_cnt_o=1.
2. Same setup, coeff_ready_i low for 3 cycles while C1 is valid -> C1 held for 3 cycles, no fifo_rd_en_o during the stall, sequence otherwise unchanged; total completion delayed by 3 cycles.
3. Two back-to-back requests with n=3 -> the second stream replays identical C0..C2 after redo; eval_cnt_o=2; exactly two fifo_redo_o pulses.
4. Armed, fifo_empty_i=1, eval_req_i -> err_o=1, state IDLE, armed_o=0, no fifo_rd_en_o. A later eval_req_i without a marker is ignored.
5. clear_i asserted while the 2nd of 5 coefficients is valid -> coeff_valid_o=0 next cycle, no redo or done, armed_o=0, err_o=0, eval_cnt_o unchanged.
6. eval_req_i with n_coeff_i=0, then n_coeff_i=MAX_COEFF+1 -> err_o=1, armed_o stays 1, no FIFO traffic. A subsequent valid n=2 request completes normally with err_o remaining 1.
